dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter AW, default 8, memory address width; SHALL match the data-memory address port.
REQ-002 Parameter DW, default 32, memory data width.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0/req1  input  1  access request per port; held high, with its we/addr/wdata stable, until that port's ack.
REQ-006 we0/we1  input  1  1 = write, 0 = read.
REQ-007 addr0/addr1  input  AW  word address.
REQ-008 wdata0/wdata1  input  DW  write data.
REQ-009 ack0/ack1  output  1  one-cycle completion pulse.
REQ-010 rdata0/rdata1  output  DW  registered read data, valid from ack onward.
REQ-011 mem_we  output  1  to data-memory write enable.
REQ-012 mem_addr  output  AW  to data-memory address.
REQ-013 mem_din  output  DW  to data-memory write data.
REQ-014 mem_dout  input  DW  combinational read data from data memory.
REQ-015 busy  output  1  high while in ACCESS.

Function
REQ-016 FSM states: IDLE, ACCESS; exactly one memory access per ACCESS cycle.
REQ-017 IDLE: port i eligible iff req_i high and ack_i low (owner masked during its ack cycle); if any eligible, latch owner, we, addr, wdata at the edge and enter ACCESS; else stay in IDLE.
REQ-018 ACCESS: drive mem_addr/mem_din from latched regs; mem_we = latched we; at the next edge return to IDLE, pulse ack_owner high one cycle, load rdata_owner from mem_dout (reads only; writes leave rdata unchanged).
REQ-019 mem_we SHALL be 0 in every IDLE cycle; mem_addr/mem_din hold last latched values in IDLE.
REQ-020 Latency: req sampled at edge k -> memory access in cycle k..k+1 -> ack high in cycle k+1..k+2.
REQ-021 Throughput: back-to-back grants every 2 cycles; the IDLE cycle carrying ack_i may grant the other port.
REQ-022 Both eligible: winner per REQ-028/REQ-029; loser stays pending, no request lost.
REQ-023 ack0 and ack1 SHALL never be high in the same cycle; non-owner rdata unchanged.
REQ-024 Request dropped before grant: no access, no ack; request changes during ACCESS ignored (latched values used).

Reset
REQ-025 rst_n low asynchronously forces: state IDLE, mem_we 0, ack0/ack1 0, busy 0, rdata0/rdata1 0, latched addr/wdata/we 0, last-grant pointer = port 1.
REQ-026 Reset during ACCESS aborts the access: mem_we drops immediately, no ack issued, no rdata update.
REQ-027 First eligible cycle after reset release arbitrates normally.

Configuration
REQ-028 Macro DM_ARB_RR_EN defined: round-robin; on contention grant the port not granted last; pointer updates on each grant.
REQ-029 Macro undefined: fixed priority, port 0 always wins contention; pointer logic absent; port 1 may starve.

Verification
REQ-030 Single write: req0, we0=1, addr0=0x10, wdata0=0xDEADBEEF -> mem_we high one cycle with mem_addr=0x10, ack0 one cycle later; subsequent read port 1 addr 0x10 -> rdata1=0xDEADBEEF at ack1.
REQ-031 Contention with DM_ARB_RR_EN: req0 and req1 held continuously after reset -> ack0, ack1, ack0, ack1 every 2 cycles; without macro -> ack0 only, ack1 never.
REQ-032 Read latency: req1 read addr 0xFF at edge k -> ack1 at k+2 cycle, rdata1 = memory content of 0xFF, rdata0 unchanged.
REQ-033 Reset mid-ACCESS: assert rst_n low during write ACCESS to 0x20 -> mem_we 0 immediately, no ack, all outputs 0; memory 0x20 unchanged.
REQ-034 Request withdrawn: pulse req1 low before grant while port 0 owns -> no ack1, no memory access for port 1.
REQ-035 Assertion checks every cycle: ack0&ack1 never, mem_we implies busy, ack pulses never longer than one cycle.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two requesting ports, dm_arbiter and the data memory.
interface dm_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        output ack0, ack1, rdata0, rdata1, mem_we, mem_addr, mem_din, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  ack0, ack1, rdata0, rdata1, mem_we, mem_addr, mem_din, busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: one memory access per ACCESS cycle, ack pulse on return to IDLE.
// Define DM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module dm_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    dm_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state;
    state_t        stateNext;
    logic          owner;
    logic          latchedWe;
    logic [AW-1:0] latchedAddr;
    logic [DW-1:0] latchedWdata;
    logic          ack0Q;
    logic          ack1Q;
    logic [DW-1:0] rdata0Q;
    logic [DW-1:0] rdata1Q;
    logic          elig0;
    logic          elig1;
    logic          grantAny;
    logic          grantPort;
`ifdef DM_ARB_RR_EN
    logic          lastGrant;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A port is masked during its own ack cycle so a held request is not served twice.
    always_comb begin
        elig0     = bus.req0 & ~ack0Q;
        elig1     = bus.req1 & ~ack1Q;
`ifdef DM_ARB_RR_EN
        grantAny  = elig0 | elig1;
        grantPort = elig1 & (~elig0 | ~lastGrant);
`else
        // A still-asserted port 0 request blocks port 1 even while port 0 is masked.
        grantAny  = elig0 | (elig1 & ~bus.req0);
        grantPort = ~elig0;
`endif
        stateNext = state;
        case (state)
            IDLE:    if (grantAny) stateNext = ACCESS;
            ACCESS:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner        <= 1'b0;
            latchedWe    <= 1'b0;
            latchedAddr  <= '0;
            latchedWdata <= '0;
            ack0Q        <= 1'b0;
            ack1Q        <= 1'b0;
            rdata0Q      <= '0;
            rdata1Q      <= '0;
`ifdef DM_ARB_RR_EN
            lastGrant    <= 1'b1;
`endif
        end else begin
            if (state == IDLE && grantAny) begin
                owner        <= grantPort;
                latchedWe    <= grantPort ? bus.we1    : bus.we0;
                latchedAddr  <= grantPort ? bus.addr1  : bus.addr0;
                latchedWdata <= grantPort ? bus.wdata1 : bus.wdata0;
`ifdef DM_ARB_RR_EN
                lastGrant    <= grantPort;
`endif
            end
            ack0Q <= (state == ACCESS) && !owner;
            ack1Q <= (state == ACCESS) && owner;
            if (state == ACCESS && !latchedWe) begin
                if (owner) begin
                    rdata1Q <= bus.mem_dout;
                end else begin
                    rdata0Q <= bus.mem_dout;
                end
            end
        end
    end

    always_comb begin
        bus.busy     = (state == ACCESS);
        bus.mem_we   = (state == ACCESS) && latchedWe;
        bus.mem_addr = latchedAddr;
        bus.mem_din  = latchedWdata;
        bus.ack0     = ack0Q;
        bus.ack1     = ack1Q;
        bus.rdata0   = rdata0Q;
        bus.rdata1   = rdata1Q;
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural 256-word data memory.
module tb_dm_arbiter;

    logic clk;
    logic rst_n;
    int   compareCount;
    int   mismatchCount;
    logic prevAck0;
    logic prevAck1;
    logic preloaded;
    logic [31:0] mem [0:255];
    logic [1:0]  expPattern [0:7];
    logic [31:0] expRdata1AfterContention;
    int          edges;

    dm_arbiter_if #(.AW(8), .DW(32)) bus ();

    dm_arbiter #(.AW(8), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory is preloaded on the first edge, which always falls inside reset.
    initial preloaded = 1'b0;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'hFF] <= 32'hCAFE_F00D;
            mem[8'h20] <= 32'h1234_5678;
            preloaded  <= 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_din;
        end
    end
    assign bus.mem_dout = mem[bus.mem_addr];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [7:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitAck(input int port, input int maxEdges, output int count);
        logic got;
        got   = 1'b0;
        count = 0;
        while (!got && count < maxEdges) begin
            tick();
            count++;
            got = (port == 0) ? bus.ack0 : bus.ack1;
        end
        if (!got) checkOutput("ackTimeout", 32'd0, 32'd1);
    endtask

    // Per-cycle protocol invariants, ignored while reset is held.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("ackExcl", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
            checkOutput("weImpliesBusy", {31'd0, bus.mem_we & ~bus.busy}, 32'd0);
            checkOutput("ack0Pulse", {31'd0, bus.ack0 & prevAck0}, 32'd0);
            checkOutput("ack1Pulse", {31'd0, bus.ack1 & prevAck1}, 32'd0);
            prevAck0 <= bus.ack0;
            prevAck1 <= bus.ack1;
        end else begin
            prevAck0 <= 1'b0;
            prevAck1 <= 1'b0;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
`ifdef DM_ARB_RR_EN
        expPattern = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        expRdata1AfterContention = 32'hCAFE_F00D;
`else
        expPattern = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
        expRdata1AfterContention = 32'h0;
`endif
        rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstBusy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rstMemWe", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("rstAck0", {31'd0, bus.ack0}, 32'd0);
        checkOutput("rstAck1", {31'd0, bus.ack1}, 32'd0);
        checkOutput("rstRdata0", bus.rdata0, 32'd0);
        checkOutput("rstRdata1", bus.rdata1, 32'd0);
        checkOutput("rstMemAddr", {24'd0, bus.mem_addr}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Single write from port 0, then read it back through port 1.
        tick();
        applyStimulus(0, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("wrIdleMemWe", {31'd0, bus.mem_we}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("wrBusy", {31'd0, bus.busy}, 32'd1);
        checkOutput("wrMemWe", {31'd0, bus.mem_we}, 32'd1);
        checkOutput("wrMemAddr", {24'd0, bus.mem_addr}, 32'h10);
        checkOutput("wrMemDin", bus.mem_din, 32'hDEAD_BEEF);
        checkOutput("wrEarlyAck0", {31'd0, bus.ack0}, 32'd0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        checkOutput("wrAck0", {31'd0, bus.ack0}, 32'd1);
        checkOutput("wrAckMemWe", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("wrHoldAddr", {24'd0, bus.mem_addr}, 32'h10);
        tick();
        @(negedge clk);
        checkOutput("wrAck0Gone", {31'd0, bus.ack0}, 32'd0);
        checkOutput("wrMem10", mem[8'h10], 32'hDEAD_BEEF);

        tick();
        applyStimulus(1, 1'b1, 1'b0, 8'h10, 32'h0);
        waitAck(1, 8, edges);
        applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0);
        checkOutput("rd1Latency", edges, 32'd2);
        @(negedge clk);
        checkOutput("rd1Data", bus.rdata1, 32'hDEAD_BEEF);
        checkOutput("rd1Rdata0", bus.rdata0, 32'd0);

        tick();
        applyStimulus(0, 1'b1, 1'b0, 8'h10, 32'h0);
        waitAck(0, 8, edges);
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0);
        checkOutput("rd0Latency", edges, 32'd2);
        @(negedge clk);
        checkOutput("rd0Data", bus.rdata0, 32'hDEAD_BEEF);

        tick();
        applyStimulus(1, 1'b1, 1'b0, 8'hFF, 32'h0);
        waitAck(1, 8, edges);
        applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0);
        checkOutput("rdFFLatency", edges, 32'd2);
        @(negedge clk);
        checkOutput("rdFFData", bus.rdata1, 32'hCAFE_F00D);
        checkOutput("rdFFRdata0", bus.rdata0, 32'hDEAD_BEEF);

        // Continuous contention straight out of reset.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(0, 1'b1, 1'b0, 8'h10, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 8'hFF, 32'h0);
        for (int e = 0; e < 8; e++) begin
            tick();
            checkOutput($sformatf("contend%0d", e + 1), {30'd0, bus.ack1, bus.ack0}, {30'd0, expPattern[e]});
        end
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        tick();
        @(negedge clk);
        checkOutput("contendRdata0", bus.rdata0, 32'hDEAD_BEEF);
        checkOutput("contendRdata1", bus.rdata1, expRdata1AfterContention);

        // Port 1 withdraws its request while port 0 owns the memory.
        tick();
        applyStimulus(0, 1'b1, 1'b1, 8'h30, 32'h1111_2222);
        tick();
        applyStimulus(1, 1'b1, 1'b1, 8'h40, 32'h5555_6666);
        tick();
        checkOutput("wdAck0", {31'd0, bus.ack0}, 32'd1);
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("wdNoAck1", {31'd0, bus.ack1}, 32'd0);
            checkOutput("wdNoMemWe", {31'd0, bus.mem_we}, 32'd0);
        end
        checkOutput("wdMem30", mem[8'h30], 32'h1111_2222);
        checkOutput("wdMem40", mem[8'h40], 32'h0);

        // Reset asserted in the middle of a write access.
        tick();
        applyStimulus(0, 1'b1, 1'b1, 8'h20, 32'hBAD0_BAD0);
        tick();
        #2;
        checkOutput("midPreMemWe", {31'd0, bus.mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midMemWe", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("midBusy", {31'd0, bus.busy}, 32'd0);
        checkOutput("midAck0", {31'd0, bus.ack0}, 32'd0);
        checkOutput("midRdata0", bus.rdata0, 32'd0);
        checkOutput("midRdata1", bus.rdata1, 32'd0);
        checkOutput("midMemAddr", {24'd0, bus.mem_addr}, 32'd0);
        checkOutput("midMemDin", bus.mem_din, 32'd0);
        applyStimulus(0, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("midMem20", mem[8'h20], 32'h1234_5678);
        checkOutput("midNoAck0", {31'd0, bus.ack0}, 32'd0);
        tick();
        rst_n = 1'b1;

        // First request after reset release is served with normal latency.
        tick();
        applyStimulus(1, 1'b1, 1'b0, 8'h20, 32'h0);
        waitAck(1, 8, edges);
        applyStimulus(1, 1'b0, 1'b0, 8'h00, 32'h0);
        checkOutput("postRstLatency", edges, 32'd2);
        @(negedge clk);
        checkOutput("postRstData", bus.rdata1, 32'h1234_5678);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
